// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB transfer/response encodings and bus widths shared by the matrix slave port.
package ahb_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: one-hot round-robin grant, searching upward from i_ptr with wrap.
module ahb_rr_arbiter
    import ahb_pkg::*;
#(
    parameter int MNUM = 8,
    parameter int PW   = 3
) (
    input  logic [MNUM-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [MNUM-1:0] o_gnt
);
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < MNUM; i++) begin
            w_sum = {1'b0, i_ptr} + (PW+1)'(i);
            w_idx = PW'((w_sum >= (PW+1)'(MNUM)) ? w_sum - (PW+1)'(MNUM) : w_sum);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ahb_matrix_slave_port.sv
// ahb_matrix_slave_port: per-slave output stage of the AHB multi-layer matrix.
// Arbitrates masters, muxes address/control and write data, returns per-master HREADY.
module ahb_matrix_slave_port
    import ahb_pkg::*;
#(
    parameter int MNUM = 8
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic [MNUM*ADDR_W-1:0]   im_haddr,
    input  logic [MNUM*2-1:0]        im_htrans,
    input  logic [MNUM-1:0]          im_hwrite,
    input  logic [MNUM*3-1:0]        im_hsize,
    input  logic [MNUM*3-1:0]        im_hburst,
    input  logic [MNUM*4-1:0]        im_hprot,
    input  logic [MNUM*DATA_W-1:0]   im_hwdata,
    output logic [DATA_W-1:0]        om_hrdata,
    output logic [MNUM-1:0]          om_hready,
    output logic [1:0]               om_hresp,
    output logic [ADDR_W-1:0]        os_haddr,
    output logic [1:0]               os_htrans,
    output logic                     os_hwrite,
    output logic [2:0]               os_hsize,
    output logic [2:0]               os_hburst,
    output logic [3:0]               os_hprot,
    output logic [DATA_W-1:0]        os_hwdata,
    output logic                     os_hsel,
    input  logic [DATA_W-1:0]        is_hrdata,
    input  logic                     is_hready,
    input  logic [1:0]               is_hresp
);
    localparam int PW = ptr_w(MNUM);

    if (MNUM < 1 || MNUM > 16) begin : g_bad_mnum
        $fatal(1, "ahb_matrix_slave_port: MNUM=%0d outside 1..16", MNUM);
    end

    logic [MNUM-1:0] r_downer;
    logic [MNUM-1:0] r_aowner;
    logic [PW-1:0]   r_rrptr;
    logic [MNUM-1:0] w_req;
    logic [MNUM-1:0] w_active;
    logic [MNUM-1:0] w_nonseq;
    logic [MNUM-1:0] w_hold;
    logic [MNUM-1:0] w_rr_gnt;
    logic [MNUM-1:0] w_grant;
    logic [PW-1:0]   w_next_ptr;
    logic            w_ptr_upd;

    // The current owner keeps the bus through a burst, and also for a pipelined
    // NONSEQ while it owns the data phase, so it never sees two HREADY sources.
    always_comb begin
        w_req    = '0;
        w_active = '0;
        w_nonseq = '0;
        w_hold   = '0;
        for (int m = 0; m < MNUM; m++) begin
            w_req[m]    = im_htrans[2*m+1];
            w_active[m] = im_htrans[2*m+:2] != HTRANS_IDLE;
            w_nonseq[m] = im_htrans[2*m+:2] == HTRANS_NONSEQ;
            w_hold[m]   = r_aowner[m] && (im_htrans[2*m+:2] == HTRANS_SEQ ||
                          im_htrans[2*m+:2] == HTRANS_BUSY || (r_downer[m] && w_nonseq[m]));
        end
    end

    ahb_rr_arbiter #(.MNUM(MNUM), .PW(PW)) u_arb (
        .i_req (w_req),
        .i_ptr (r_rrptr),
        .o_gnt (w_rr_gnt)
    );

    assign w_grant   = hreset ? '0 : (|w_hold ? w_hold : w_rr_gnt);
    assign os_hsel   = |w_grant;
    assign om_hrdata = is_hrdata;
    assign om_hresp  = is_hresp;

    always_comb begin
        os_haddr   = '0;
        os_htrans  = HTRANS_IDLE;
        os_hwrite  = 1'b0;
        os_hsize   = '0;
        os_hburst  = '0;
        os_hprot   = '0;
        os_hwdata  = '0;
        om_hready  = '1;
        w_ptr_upd  = 1'b0;
        w_next_ptr = '0;
        for (int m = 0; m < MNUM; m++) begin
            if (w_grant[m]) begin
                os_haddr  = im_haddr[ADDR_W*m+:ADDR_W];
                os_htrans = im_htrans[2*m+:2];
                os_hwrite = im_hwrite[m];
                os_hsize  = im_hsize[3*m+:3];
                os_hburst = im_hburst[3*m+:3];
                os_hprot  = im_hprot[4*m+:4];
                if (w_nonseq[m]) begin
                    w_ptr_upd  = 1'b1;
                    w_next_ptr = (m == MNUM-1) ? '0 : PW'(m+1);
                end
            end
            if (r_downer[m] && !hreset)
                os_hwdata = im_hwdata[DATA_W*m+:DATA_W];
            om_hready[m] = hreset || ((r_downer[m] || w_grant[m]) ? is_hready : !w_req[m]);
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_downer <= '0;
            r_aowner <= '0;
            r_rrptr  <= '0;
        end else if (is_hready) begin
            r_downer <= w_grant & w_active;
            r_aowner <= w_grant;
            if (w_ptr_upd)
                r_rrptr <= w_next_ptr;
        end
    end
endmodule

// File: tb/tb_ahb_matrix_slave_port.sv
// tb_ahb_matrix_slave_port: directed scenarios plus randomized traffic against an index-level model.
module tb_ahb_matrix_slave_port;
    localparam int M = 8;
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NS   = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic            hclk = 1'b0;
    logic            hreset = 1'b1;
    logic [M*32-1:0] im_haddr;
    logic [M*2-1:0]  im_htrans;
    logic [M-1:0]    im_hwrite;
    logic [M*3-1:0]  im_hsize;
    logic [M*3-1:0]  im_hburst;
    logic [M*4-1:0]  im_hprot;
    logic [M*32-1:0] im_hwdata;
    logic [31:0]     om_hrdata;
    logic [M-1:0]    om_hready;
    logic [1:0]      om_hresp;
    logic [31:0]     os_haddr;
    logic [1:0]      os_htrans;
    logic            os_hwrite;
    logic [2:0]      os_hsize;
    logic [2:0]      os_hburst;
    logic [3:0]      os_hprot;
    logic [31:0]     os_hwdata;
    logic            os_hsel;
    logic [31:0]     is_hrdata;
    logic            is_hready;
    logic [1:0]      is_hresp;

    logic [31:0] a_addr  [M];
    logic [31:0] a_wdata [M];
    logic [1:0]  a_trans [M];
    logic        a_write [M];
    logic [2:0]  a_size  [M];
    logic [2:0]  a_burst [M];
    logic [3:0]  a_prot  [M];

    int checks = 0;
    int failures = 0;

    // Model state as plain master indices: -1 means nobody.
    int m_down = -1;
    int m_aown = -1;
    int m_ptr  = 0;

    ahb_matrix_slave_port #(.MNUM(M)) dut (
        .hclk(hclk), .hreset(hreset),
        .im_haddr(im_haddr), .im_htrans(im_htrans), .im_hwrite(im_hwrite),
        .im_hsize(im_hsize), .im_hburst(im_hburst), .im_hprot(im_hprot),
        .im_hwdata(im_hwdata),
        .om_hrdata(om_hrdata), .om_hready(om_hready), .om_hresp(om_hresp),
        .os_haddr(os_haddr), .os_htrans(os_htrans), .os_hwrite(os_hwrite),
        .os_hsize(os_hsize), .os_hburst(os_hburst), .os_hprot(os_hprot),
        .os_hwdata(os_hwdata), .os_hsel(os_hsel),
        .is_hrdata(is_hrdata), .is_hready(is_hready), .is_hresp(is_hresp)
    );

    always #5 hclk = ~hclk;

    always_comb begin
        im_haddr  = '0;
        im_htrans = '0;
        im_hwrite = '0;
        im_hsize  = '0;
        im_hburst = '0;
        im_hprot  = '0;
        im_hwdata = '0;
        for (int m = 0; m < M; m++) begin
            im_haddr[32*m+:32]  = a_addr[m];
            im_htrans[2*m+:2]   = a_trans[m];
            im_hwrite[m]        = a_write[m];
            im_hsize[3*m+:3]    = a_size[m];
            im_hburst[3*m+:3]   = a_burst[m];
            im_hprot[4*m+:4]    = a_prot[m];
            im_hwdata[32*m+:32] = a_wdata[m];
        end
    end

    function automatic int exp_grant();
        if (hreset)
            return -1;
        if (m_aown >= 0) begin
            if (a_trans[m_aown] == T_SEQ || a_trans[m_aown] == T_BUSY ||
                (a_trans[m_aown] == T_NS && m_down == m_aown))
                return m_aown;
        end
        for (int i = 0; i < M; i++) begin
            if (a_trans[(m_ptr + i) % M][1])
                return (m_ptr + i) % M;
        end
        return -1;
    endfunction

    always @(posedge hclk) begin
        int g;
        g = exp_grant();
        if (hreset) begin
            m_down = -1;
            m_aown = -1;
            m_ptr  = 0;
        end else if (is_hready) begin
            m_aown = g;
            m_down = (g >= 0 && a_trans[g] != T_IDLE) ? g : -1;
            if (g >= 0 && a_trans[g] == T_NS)
                m_ptr = (g + 1) % M;
        end
    end

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_all();
        for (int m = 0; m < M; m++) a_trans[m] = T_IDLE;
        is_hready = 1'b1;
        is_hresp  = 2'b00;
    endtask

    task automatic do_reset();
        hreset = 1'b1;
        idle_all();
        step();
        hreset = 1'b0;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        idle_all();
        a_trans[0] = T_NS;
        a_trans[1] = T_NS;
        step();
        for (int c = 0; c < 2; c++) begin
            #3;
            checks++; if (os_htrans !== 2'b00) begin failures++; $display("FAIL reset_htrans got=%b exp=00", os_htrans); end
            checks++; if (os_hsel !== 1'b0) begin failures++; $display("FAIL reset_hsel got=%b exp=0", os_hsel); end
            checks++; if (om_hready !== {M{1'b1}}) begin failures++; $display("FAIL reset_hready got=%b exp=%b", om_hready, {M{1'b1}}); end
            step();
        end
        hreset = 1'b0;
        idle_all();
        step();
    endtask

    task automatic test_single_write();
        logic [31:0] wd;
        wd = $urandom;
        idle_all();
        a_trans[2] = T_NS;
        a_addr[2]  = 32'h1000;
        a_write[2] = 1'b1;
        a_wdata[2] = wd;
        #3;
        checks++; if (os_haddr !== 32'h1000) begin failures++; $display("FAIL write_addr got=%h exp=00001000", os_haddr); end
        checks++; if (os_htrans !== T_NS) begin failures++; $display("FAIL write_htrans got=%b exp=10", os_htrans); end
        checks++; if (os_hsel !== 1'b1) begin failures++; $display("FAIL write_hsel got=%b exp=1", os_hsel); end
        checks++; if (os_hwrite !== 1'b1) begin failures++; $display("FAIL write_hwrite got=%b exp=1", os_hwrite); end
        step();
        a_trans[2] = T_IDLE;
        #3;
        checks++; if (os_hwdata !== wd) begin failures++; $display("FAIL write_hwdata got=%h exp=%h", os_hwdata, wd); end
        checks++; if (om_hready[2] !== 1'b1) begin failures++; $display("FAIL write_hready2 got=%b exp=1", om_hready[2]); end
        checks++; if (os_hsel !== 1'b0) begin failures++; $display("FAIL write_hsel_off got=%b exp=0", os_hsel); end
        step();
    endtask

    task automatic test_contention();
        do_reset();
        a_addr[0]  = $urandom;
        a_addr[3]  = a_addr[0] ^ 32'h0000_0100;
        a_addr[5]  = a_addr[0] ^ 32'h0000_0200;
        a_trans[0] = T_NS;
        a_trans[3] = T_NS;
        #3;
        checks++; if (os_haddr !== a_addr[0]) begin failures++; $display("FAIL cont_first_addr got=%h exp=%h", os_haddr, a_addr[0]); end
        checks++; if (om_hready[3] !== 1'b0) begin failures++; $display("FAIL cont_stall3 got=%b exp=0", om_hready[3]); end
        step();
        a_trans[0] = T_IDLE;
        #3;
        checks++; if (os_haddr !== a_addr[3]) begin failures++; $display("FAIL cont_second_addr got=%h exp=%h", os_haddr, a_addr[3]); end
        checks++; if (om_hready[3] !== 1'b1) begin failures++; $display("FAIL cont_ready3 got=%b exp=1", om_hready[3]); end
        step();
        a_trans[3] = T_IDLE;
        a_trans[2] = T_NS;
        a_trans[5] = T_NS;
        #3;
        checks++; if (os_haddr !== a_addr[5]) begin failures++; $display("FAIL cont_ptr4_addr got=%h exp=%h", os_haddr, a_addr[5]); end
        checks++; if (om_hready[2] !== 1'b0) begin failures++; $display("FAIL cont_stall2 got=%b exp=0", om_hready[2]); end
        step();
        idle_all();
        step();
    endtask

    task automatic test_wait_states();
        logic [31:0] wd, base;
        wd   = $urandom;
        base = $urandom & 32'hFFFF_FFF0;
        do_reset();
        a_trans[1] = T_NS;
        a_addr[1]  = base;
        a_wdata[1] = wd;
        step();
        a_addr[1]  = base + 32'd4;
        a_trans[4] = T_NS;
        a_addr[4]  = base ^ 32'h8000_0000;
        is_hready  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #3;
            checks++; if (om_hready[1] !== 1'b0) begin failures++; $display("FAIL wait_ready1 c=%0d got=%b exp=0", c, om_hready[1]); end
            checks++; if (os_haddr !== base + 32'd4) begin failures++; $display("FAIL wait_addr c=%0d got=%h exp=%h", c, os_haddr, base + 32'd4); end
            checks++; if (os_hwdata !== wd) begin failures++; $display("FAIL wait_hwdata c=%0d got=%h exp=%h", c, os_hwdata, wd); end
            checks++; if (om_hready[4] !== 1'b0) begin failures++; $display("FAIL wait_stall4 c=%0d got=%b exp=0", c, om_hready[4]); end
            step();
        end
        is_hready = 1'b1;
        #3;
        checks++; if (om_hready[1] !== 1'b1) begin failures++; $display("FAIL wait_done1 got=%b exp=1", om_hready[1]); end
        checks++; if (os_haddr !== base + 32'd4) begin failures++; $display("FAIL wait_done_addr got=%h exp=%h", os_haddr, base + 32'd4); end
        step();
        a_trans[1] = T_IDLE;
        #3;
        checks++; if (os_haddr !== a_addr[4]) begin failures++; $display("FAIL wait_next4 got=%h exp=%h", os_haddr, a_addr[4]); end
        step();
        idle_all();
        step();
    endtask

    task automatic test_burst_lock();
        logic [1:0]  bt [5];
        logic [31:0] base;
        int k;
        bt   = '{T_NS, T_SEQ, T_BUSY, T_SEQ, T_SEQ};
        base = $urandom & 32'hFFFF_FF00;
        k    = 0;
        do_reset();
        a_burst[1] = 3'b011;
        a_trans[2] = T_NS;
        a_addr[2]  = base ^ 32'h0001_0000;
        for (int i = 0; i < 5; i++) begin
            a_trans[1] = bt[i];
            a_addr[1]  = base + 32'(4 * k);
            if (bt[i] != T_BUSY) k++;
            #3;
            checks++; if (os_haddr !== a_addr[1]) begin failures++; $display("FAIL burst_addr beat=%0d got=%h exp=%h", i, os_haddr, a_addr[1]); end
            checks++; if (os_htrans !== bt[i]) begin failures++; $display("FAIL burst_htrans beat=%0d got=%b exp=%b", i, os_htrans, bt[i]); end
            checks++; if (os_hburst !== 3'b011) begin failures++; $display("FAIL burst_hburst beat=%0d got=%b exp=011", i, os_hburst); end
            checks++; if (om_hready[2] !== 1'b0) begin failures++; $display("FAIL burst_stall2 beat=%0d got=%b exp=0", i, om_hready[2]); end
            step();
        end
        a_trans[1] = T_IDLE;
        #3;
        checks++; if (os_haddr !== a_addr[2]) begin failures++; $display("FAIL burst_handover got=%h exp=%h", os_haddr, a_addr[2]); end
        checks++; if (om_hready[2] !== 1'b1) begin failures++; $display("FAIL burst_ready2 got=%b exp=1", om_hready[2]); end
        step();
        idle_all();
        step();
    endtask

    task automatic test_error();
        logic [31:0] rd;
        do_reset();
        a_trans[0] = T_NS;
        step();
        a_addr[0] = a_addr[0] + 32'd4;
        rd        = $urandom;
        is_hrdata = rd;
        is_hready = 1'b0;
        is_hresp  = 2'b01;
        #3;
        checks++; if (om_hresp !== 2'b01) begin failures++; $display("FAIL err1_hresp got=%b exp=01", om_hresp); end
        checks++; if (om_hready[0] !== 1'b0) begin failures++; $display("FAIL err1_ready0 got=%b exp=0", om_hready[0]); end
        checks++; if (om_hrdata !== rd) begin failures++; $display("FAIL err_hrdata got=%h exp=%h", om_hrdata, rd); end
        step();
        a_trans[0] = T_IDLE;
        is_hready  = 1'b1;
        #3;
        checks++; if (om_hresp !== 2'b01) begin failures++; $display("FAIL err2_hresp got=%b exp=01", om_hresp); end
        checks++; if (om_hready[0] !== 1'b1) begin failures++; $display("FAIL err2_ready0 got=%b exp=1", om_hready[0]); end
        checks++; if (os_hsel !== 1'b0) begin failures++; $display("FAIL err2_hsel got=%b exp=0", os_hsel); end
        step();
        idle_all();
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_trans[3] = T_NS;
        a_wdata[3] = $urandom | 32'h1;
        step();
        a_trans[3] = T_IDLE;
        a_trans[6] = T_NS;
        is_hready  = 1'b0;
        hreset     = 1'b1;
        #3;
        checks++; if (om_hready !== {M{1'b1}}) begin failures++; $display("FAIL rstmid_ready got=%b exp=%b", om_hready, {M{1'b1}}); end
        checks++; if (os_hsel !== 1'b0) begin failures++; $display("FAIL rstmid_hsel got=%b exp=0", os_hsel); end
        step();
        hreset = 1'b0;
        idle_all();
        #3;
        checks++; if (os_hwdata !== 32'd0) begin failures++; $display("FAIL rstmid_hwdata got=%h exp=0", os_hwdata); end
        checks++; if (om_hready !== {M{1'b1}}) begin failures++; $display("FAIL rstmid_ready_after got=%b exp=%b", om_hready, {M{1'b1}}); end
        step();
    endtask

    task automatic test_random();
        int g, r;
        logic [31:0] e_addr, e_wdata;
        logic [1:0]  e_trans;
        logic [10:0] e_ctrl;
        logic [M-1:0] e_ready;
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < M; m++) begin
                r = $urandom_range(0, 9);
                a_trans[m] = (r < 5) ? T_IDLE : (r < 7) ? T_NS : (r < 9) ? T_SEQ : T_BUSY;
                a_addr[m]  = $urandom;
                a_wdata[m] = $urandom;
                a_write[m] = 1'($urandom);
                a_size[m]  = 3'($urandom);
                a_burst[m] = 3'($urandom);
                a_prot[m]  = 4'($urandom);
            end
            is_hready = ($urandom_range(0, 3) != 0);
            is_hresp  = 2'($urandom_range(0, 1));
            is_hrdata = $urandom;
            hreset    = ($urandom_range(0, 49) == 0);
            #3;
            g       = exp_grant();
            e_addr  = (g < 0) ? 32'd0 : a_addr[g];
            e_trans = (g < 0) ? T_IDLE : a_trans[g];
            e_ctrl  = (g < 0) ? 11'd0 : {a_write[g], a_size[g], a_burst[g], a_prot[g]};
            e_wdata = (m_down < 0) ? 32'd0 : a_wdata[m_down];
            for (int m = 0; m < M; m++)
                e_ready[m] = hreset ? 1'b1 : (m == m_down || m == g) ? is_hready : !a_trans[m][1];
            checks++; if (os_haddr !== e_addr) begin failures++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, os_haddr, e_addr); end
            checks++; if (os_htrans !== e_trans) begin failures++; $display("FAIL rnd_htrans c=%0d got=%b exp=%b", c, os_htrans, e_trans); end
            checks++; if ({os_hwrite, os_hsize, os_hburst, os_hprot} !== e_ctrl) begin failures++; $display("FAIL rnd_ctrl c=%0d got=%h exp=%h", c, {os_hwrite, os_hsize, os_hburst, os_hprot}, e_ctrl); end
            checks++; if (os_hsel !== (g >= 0)) begin failures++; $display("FAIL rnd_hsel c=%0d got=%b exp=%b", c, os_hsel, (g >= 0)); end
            checks++; if (om_hready !== e_ready) begin failures++; $display("FAIL rnd_hready c=%0d got=%b exp=%b", c, om_hready, e_ready); end
            checks++; if ({om_hrdata, om_hresp} !== {is_hrdata, is_hresp}) begin failures++; $display("FAIL rnd_passthru c=%0d got=%h/%b exp=%h/%b", c, om_hrdata, om_hresp, is_hrdata, is_hresp); end
            if (!hreset) begin
                checks++; if (os_hwdata !== e_wdata) begin failures++; $display("FAIL rnd_hwdata c=%0d got=%h exp=%h", c, os_hwdata, e_wdata); end
            end
            step();
        end
        hreset = 1'b0;
        idle_all();
        step();
    endtask

    initial begin
        for (int m = 0; m < M; m++) begin
            a_addr[m]  = '0;
            a_wdata[m] = '0;
            a_trans[m] = T_IDLE;
            a_write[m] = 1'b0;
            a_size[m]  = 3'b010;
            a_burst[m] = 3'b000;
            a_prot[m]  = 4'b0011;
        end
        is_hrdata = '0;
        is_hready = 1'b1;
        is_hresp  = 2'b00;
        test_reset();
        test_single_write();
        test_contention();
        test_wait_states();
        test_burst_lock();
        test_error();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
